bs_tap_ctrl: RTL and testbench
==============================

# bs_tap_ctrl

IEEE 1149.1 TAP controller that sequences the boundary-scan chain built from `bscell` instances. It decodes TMS into the 16-state TAP FSM and holds a 4-bit instruction register. It drives the shared shift/capture/update/enable/mode strobes to every boundary cell, owns the BYPASS and IDCODE data registers, and muxes the selected register onto TDO. It sits between the chip-level JTAG pads and the boundary cell chain.

## Interface
- `IDCODE_VALUE`, default `32'h1000_0DB3`: value captured by the IDCODE register. Bit 0 must be 1.
- `clk_i` input, 1 bit: TCK.
- `rst_ni` input, 1 bit: TRST. Reset is `rst_ni`, asynchronous, active-low; clock is `clk_i`.
- `tms_i` input, 1 bit: TMS, sampled on rising edge of `clk_i`.
- `tdi_i` input, 1 bit: TDI, sampled on rising edge of `clk_i`.
- `tdo_o` output, 1 bit: TDO, registered on falling edge of `clk_i`.
- `tdo_oe_o` output, 1 bit: TDO pad enable, registered on falling edge.
- `bs_scan_in_o` output, 1 bit: chain head input, equal to `tdi_i`.
- `bs_scan_out_i` input, 1 bit: chain tail (last cell `scan_out_o`).
- `bs_shift_dr_o` / `bs_capture_dr_o` / `bs_update_dr_o` outputs, 1 bit each: chain strobes.
- `bs_enable_o` output, 1 bit: chain selected (EXTEST or SAMPLE_PRELOAD).
- `bs_mode_o` output, 1 bit: cells drive pins from update latch (EXTEST only).
- `ir_o` output, 4 bits: current instruction, for debug.

## Operation
- FSM states: TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR, and the six matching _IR states plus SELECT_IR. Transitions follow 1149.1 exactly on each rising edge of `clk_i`, using `tms_i`.
- Five consecutive TMS=1 edges reach TEST_LOGIC_RESET from any state.
- IR shift register:
  - CAPTURE_IR loads `4'b0101`.
  - SHIFT_IR shifts right, with `tdi_i` entering the MSB.
  - On the rising edge leaving UPDATE_IR, IR takes the shifted value.
  - While in TEST_LOGIC_RESET, IR is forced to the reset instruction.
- Instructions: EXTEST `0000`, SAMPLE_PRELOAD `0001`, IDCODE `0010`, BYPASS `1111`. Every other code decodes as BYPASS.
- BYPASS register (1 bit): loads 0 in CAPTURE_DR and loads `tdi_i` in SHIFT_DR.
- IDCODE register (32 bits): loads `IDCODE_VALUE` in CAPTURE_DR. In SHIFT_DR it shifts right, LSB out first, `tdi_i` into bit 31.
- Boundary-chain strobes are Moore outputs decoded from the state register:
  - `bs_shift_dr_o` = (state==SHIFT_DR) & chain selected.
  - Capture and update strobes are decoded the same way from CAPTURE_DR and UPDATE_DR.
  - All three are 0 when the chain is not selected.
- Enable and mode:
  - `bs_enable_o` = IR∈{EXTEST, SAMPLE_PRELOAD}.
  - `bs_mode_o` = IR==EXTEST.
- TDO source:
  - SHIFT_IR: IR shift LSB.
  - SHIFT_DR: LSB of the register selected by IR; `bs_scan_out_i` for chain instructions.
  - Any other state: `tdo_o` holds 0 and `tdo_oe_o` = 0.

## Timing
- Reset values:
  - State is TEST_LOGIC_RESET.
  - IR is the reset instruction.
  - IR shift register = `0000`, BYPASS = 0, IDCODE register = `IDCODE_VALUE`.
  - All strobes, `bs_enable_o`, `bs_mode_o`, `tdo_o` and `tdo_oe_o` are 0.
- Strobes assert one rising edge after the TMS value that enters the state. Each is high for exactly the cycles spent in that state. UPDATE strobes last one cycle.
- `tdo_o` and `tdo_oe_o` change on the falling edge, half a TCK after the state or shift change.
- Shift path latency TDI→TDO:
  - BYPASS: 1 TCK.
  - IDCODE: 32 TCK.
  - IR: 4 TCK.
  - Chain: N cells.
- PAUSE states hold all shift registers unchanged.
- IR change takes effect on `bs_enable_o`/`bs_mode_o` in the cycle after UPDATE_IR.
- Async reset mid-shift: every register returns to reset values immediately. Partially shifted IR is discarded.

## Configuration
- `BS_TAP_IDCODE_EN`.
  - Defined: the IDCODE register exists and the reset instruction is IDCODE (`0010`).
  - Undefined: there is no IDCODE register, `0010` decodes as BYPASS, and the reset instruction is BYPASS (`1111`).

## Test plan
- Reset, then TMS 0,1,0,0, then 32 SHIFT_DR cycles (macro on) -> `tdo_o` emits `IDCODE_VALUE` LSB first (`1,1,0,0,1,1,0,1,…`). `tdo_oe_o`=1 only during shift.
- Load IR `1111`, shift DR with TDI `1,0,1,1` -> TDO `0,1,0,1`. Capture-IR shifted out reads `1,0,1,0`.
- Load IR `0000` -> `bs_mode_o`=1 and `bs_enable_o`=1. Then in CAPTURE_DR→SHIFT_DR×8→EXIT1→UPDATE_DR:
  - `bs_capture_dr_o` is high for 1 cycle and `bs_shift_dr_o` for exactly 8 cycles.
  - `bs_update_dr_o` is high for 1 cycle.
  - TDO equals `bs_scan_out_i` delayed by half a TCK.
- IR=SAMPLE_PRELOAD -> `bs_mode_o`=0, `bs_enable_o`=1. Then 5×TMS=1 from SHIFT_DR -> TEST_LOGIC_RESET, IR=`0010`, and all bs outputs 0.
- Drop `rst_ni` mid SHIFT_DR under EXTEST -> all outputs are 0 before the next edge, and IR reads back `0010`.
- Macro off: after reset, `ir_o`=`1111`. Load `0010` and shift DR -> 1-cycle bypass behaviour.

Source files
------------

// File: rtl/bs_tap_ctrl.sv
// bs_tap_ctrl: IEEE 1149.1 TAP controller for the bscell boundary-scan chain.
// Holds the 16-state TAP FSM, a 4-bit instruction register, the BYPASS register,
// the optional IDCODE register and the TDO output mux.
// Optional feature macro: BS_TAP_IDCODE_EN.
//   Defined   -> IDCODE register present; the reset instruction is IDCODE (0010).
//   Undefined -> no IDCODE register; 0010 decodes as BYPASS; the reset instruction is BYPASS (1111).
module bs_tap_ctrl #(
   parameter logic [31:0] IDCODE_VALUE = 32'h1000_0DB3
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       tms_i,
   input  logic       tdi_i,
   output logic       tdo_o,
   output logic       tdo_oe_o,
   output logic       bs_scan_in_o,
   input  logic       bs_scan_out_i,
   output logic       bs_shift_dr_o,
   output logic       bs_capture_dr_o,
   output logic       bs_update_dr_o,
   output logic       bs_enable_o,
   output logic       bs_mode_o,
   output logic [3:0] ir_o
);

   typedef enum logic [3:0] {
      ST_TEST_LOGIC_RESET = 4'd0,
      ST_RUN_TEST_IDLE    = 4'd1,
      ST_SELECT_DR        = 4'd2,
      ST_CAPTURE_DR       = 4'd3,
      ST_SHIFT_DR         = 4'd4,
      ST_EXIT1_DR         = 4'd5,
      ST_PAUSE_DR         = 4'd6,
      ST_EXIT2_DR         = 4'd7,
      ST_UPDATE_DR        = 4'd8,
      ST_SELECT_IR        = 4'd9,
      ST_CAPTURE_IR       = 4'd10,
      ST_SHIFT_IR         = 4'd11,
      ST_EXIT1_IR         = 4'd12,
      ST_PAUSE_IR         = 4'd13,
      ST_EXIT2_IR         = 4'd14,
      ST_UPDATE_IR        = 4'd15
   } tap_state_e;

   localparam logic [3:0] INSTR_EXTEST         = 4'b0000;
   localparam logic [3:0] INSTR_SAMPLE_PRELOAD = 4'b0001;
   localparam logic [3:0] INSTR_IDCODE         = 4'b0010;
   localparam logic [3:0] INSTR_BYPASS         = 4'b1111;
   localparam logic [3:0] IR_CAPTURE_VALUE     = 4'b0101;
`ifdef BS_TAP_IDCODE_EN
   localparam logic [3:0] RESET_INSTR          = INSTR_IDCODE;
`else
   localparam logic [3:0] RESET_INSTR          = INSTR_BYPASS;
`endif

   // An IDCODE without bit 0 set would be mistaken for BYPASS by a host probing the chain.
   if (IDCODE_VALUE[0] != 1'b1) begin : g_idcode_lsb_check
      $error("bs_tap_ctrl: IDCODE_VALUE bit 0 must be 1");
   end

   tap_state_e  state_r;
   tap_state_e  state_next_s;
   logic [3:0]  ir_r;
   logic [3:0]  ir_sr_r;
   logic        bypass_r;
   logic        sel_chain_s;
   logic        sel_idcode_s;
   logic        tdo_next_s;
   logic        tdo_oe_next_s;
   logic        tdo_r;
   logic        tdo_oe_r;

   // TAP next-state decode from TMS.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_TEST_LOGIC_RESET: state_next_s = tms_i ? ST_TEST_LOGIC_RESET : ST_RUN_TEST_IDLE;
         ST_RUN_TEST_IDLE:    state_next_s = tms_i ? ST_SELECT_DR : ST_RUN_TEST_IDLE;
         ST_SELECT_DR:        state_next_s = tms_i ? ST_SELECT_IR : ST_CAPTURE_DR;
         ST_CAPTURE_DR:       state_next_s = tms_i ? ST_EXIT1_DR  : ST_SHIFT_DR;
         ST_SHIFT_DR:         state_next_s = tms_i ? ST_EXIT1_DR  : ST_SHIFT_DR;
         ST_EXIT1_DR:         state_next_s = tms_i ? ST_UPDATE_DR : ST_PAUSE_DR;
         ST_PAUSE_DR:         state_next_s = tms_i ? ST_EXIT2_DR  : ST_PAUSE_DR;
         ST_EXIT2_DR:         state_next_s = tms_i ? ST_UPDATE_DR : ST_SHIFT_DR;
         ST_UPDATE_DR:        state_next_s = tms_i ? ST_SELECT_DR : ST_RUN_TEST_IDLE;
         ST_SELECT_IR:        state_next_s = tms_i ? ST_TEST_LOGIC_RESET : ST_CAPTURE_IR;
         ST_CAPTURE_IR:       state_next_s = tms_i ? ST_EXIT1_IR  : ST_SHIFT_IR;
         ST_SHIFT_IR:         state_next_s = tms_i ? ST_EXIT1_IR  : ST_SHIFT_IR;
         ST_EXIT1_IR:         state_next_s = tms_i ? ST_UPDATE_IR : ST_PAUSE_IR;
         ST_PAUSE_IR:         state_next_s = tms_i ? ST_EXIT2_IR  : ST_PAUSE_IR;
         ST_EXIT2_IR:         state_next_s = tms_i ? ST_UPDATE_IR : ST_SHIFT_IR;
         ST_UPDATE_IR:        state_next_s = tms_i ? ST_SELECT_DR : ST_RUN_TEST_IDLE;
         default:             state_next_s = ST_TEST_LOGIC_RESET;
      endcase
   end

   // TAP state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= ST_TEST_LOGIC_RESET;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Instruction shift register and instruction latch; IR is forced to the reset
   // instruction on entry to TEST_LOGIC_RESET so it already holds it in that state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ir_sr_r <= 4'b0000;
         ir_r    <= RESET_INSTR;
      end else begin
         if (state_r == ST_CAPTURE_IR) begin
            ir_sr_r <= IR_CAPTURE_VALUE;
         end else if (state_r == ST_SHIFT_IR) begin
            ir_sr_r <= {tdi_i, ir_sr_r[3:1]};
         end
         if (state_next_s == ST_TEST_LOGIC_RESET) begin
            ir_r <= RESET_INSTR;
         end else if (state_r == ST_UPDATE_IR) begin
            ir_r <= ir_sr_r;
         end
      end
   end

   // One-bit BYPASS register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bypass_r <= 1'b0;
      end else if (state_r == ST_CAPTURE_DR) begin
         bypass_r <= 1'b0;
      end else if (state_r == ST_SHIFT_DR) begin
         bypass_r <= tdi_i;
      end
   end

`ifdef BS_TAP_IDCODE_EN
   logic [31:0] idcode_r;

   // 32-bit IDCODE register, shifted out LSB first.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idcode_r <= IDCODE_VALUE;
      end else if (state_r == ST_CAPTURE_DR) begin
         idcode_r <= IDCODE_VALUE;
      end else if (state_r == ST_SHIFT_DR) begin
         idcode_r <= {tdi_i, idcode_r[31:1]};
      end
   end

   assign sel_idcode_s = (ir_r == INSTR_IDCODE);
`else
   assign sel_idcode_s = 1'b0;
`endif

   assign sel_chain_s = (ir_r == INSTR_EXTEST) || (ir_r == INSTR_SAMPLE_PRELOAD);

   // TDO source select; the pad is only driven in the two shift states.
   always_comb begin
      tdo_next_s    = 1'b0;
      tdo_oe_next_s = 1'b0;
      case (state_r)
         ST_SHIFT_IR: begin
            tdo_next_s    = ir_sr_r[0];
            tdo_oe_next_s = 1'b1;
         end
         ST_SHIFT_DR: begin
            tdo_oe_next_s = 1'b1;
            if (sel_chain_s) begin
               tdo_next_s = bs_scan_out_i;
            end else if (sel_idcode_s) begin
`ifdef BS_TAP_IDCODE_EN
               tdo_next_s = idcode_r[0];
`else
               tdo_next_s = 1'b0;
`endif
            end else begin
               tdo_next_s = bypass_r;
            end
         end
         default: begin
            tdo_next_s    = 1'b0;
            tdo_oe_next_s = 1'b0;
         end
      endcase
   end

   // TDO and its enable change on the falling edge of TCK.
   always_ff @(negedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tdo_r    <= 1'b0;
         tdo_oe_r <= 1'b0;
      end else begin
         tdo_r    <= tdo_next_s;
         tdo_oe_r <= tdo_oe_next_s;
      end
   end

   assign tdo_o           = tdo_r;
   assign tdo_oe_o        = tdo_oe_r;
   assign bs_scan_in_o    = tdi_i;
   assign bs_shift_dr_o   = (state_r == ST_SHIFT_DR)   && sel_chain_s;
   assign bs_capture_dr_o = (state_r == ST_CAPTURE_DR) && sel_chain_s;
   assign bs_update_dr_o  = (state_r == ST_UPDATE_DR)  && sel_chain_s;
   assign bs_enable_o     = sel_chain_s;
   assign bs_mode_o       = (ir_r == INSTR_EXTEST);
   assign ir_o            = ir_r;

endmodule

// File: tb/tb_bs_tap_ctrl.sv
// tb_bs_tap_ctrl: directed bench for bs_tap_ctrl (IDCODE sequence only when BS_TAP_IDCODE_EN is defined).
module tb_bs_tap_ctrl;

   localparam logic [31:0] IDV = 32'h1000_0DB3;
`ifdef BS_TAP_IDCODE_EN
   localparam logic [3:0] RESET_IR = 4'b0010;
`else
   localparam logic [3:0] RESET_IR = 4'b1111;
`endif

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       tms_i = 1'b0;
   logic       tdi_i = 1'b0;
   logic       bs_scan_out_i = 1'b0;
   logic       tdo_o, tdo_oe_o, bs_scan_in_o;
   logic       bs_shift_dr_o, bs_capture_dr_o, bs_update_dr_o, bs_enable_o, bs_mode_o;
   logic [3:0] ir_o;

   int total = 0;
   int bad   = 0;
   int ncap  = 0;
   int nsh   = 0;
   int nupd  = 0;

   bs_tap_ctrl #(.IDCODE_VALUE(IDV)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .tms_i(tms_i), .tdi_i(tdi_i),
      .tdo_o(tdo_o), .tdo_oe_o(tdo_oe_o), .bs_scan_in_o(bs_scan_in_o),
      .bs_scan_out_i(bs_scan_out_i), .bs_shift_dr_o(bs_shift_dr_o),
      .bs_capture_dr_o(bs_capture_dr_o), .bs_update_dr_o(bs_update_dr_o),
      .bs_enable_o(bs_enable_o), .bs_mode_o(bs_mode_o), .ir_o(ir_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply TMS/TDI, take one rising edge, then sample just after the falling edge.
   task automatic clk(input logic tms, input logic tdi);
      tms_i = tms;
      tdi_i = tdi;
      @(posedge clk_i);
      @(negedge clk_i);
      #1;
      ncap += int'(bs_capture_dr_o);
      nsh  += int'(bs_shift_dr_o);
      nupd += int'(bs_update_dr_o);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_tdo"}, tdo_o, 1'b0);
      chk({tag, "_oe"}, tdo_oe_o, 1'b0);
      chk({tag, "_strobes"}, {bs_capture_dr_o, bs_shift_dr_o, bs_update_dr_o}, 3'b000);
      chk({tag, "_en_mode"}, {bs_enable_o, bs_mode_o}, 2'b00);
   endtask

   // From RUN_TEST_IDLE, load instruction v and return to RUN_TEST_IDLE.
   task automatic load_ir(input logic [3:0] v);
      logic [3:0] cap;
      logic [3:0] old;
      cap = 4'b0101;
      old = ir_o;
      clk(1'b1, 1'b0);
      clk(1'b1, 1'b0);
      clk(1'b0, 1'b0);
      clk(1'b0, 1'b0);
      chk("ir_shift_oe", tdo_oe_o, 1'b1);
      for (int k = 0; k < 4; k++) begin
         chk("ir_capture_tdo", tdo_o, cap[k]);
         clk(k == 3, v[k]);
      end
      clk(1'b1, 1'b0);
      chk("ir_hold_in_update", ir_o, old);
      clk(1'b0, 1'b0);
      chk("ir_updated", ir_o, v);
   endtask

   // From RUN_TEST_IDLE to SHIFT_DR.
   task automatic dr_enter();
      clk(1'b1, 1'b0);
      clk(1'b0, 1'b0);
      clk(1'b0, 1'b0);
   endtask

   // Bypass scan: TDI 1,0,1,1 gives TDO 0,1,0,1; ends in RUN_TEST_IDLE.
   task automatic bypass_scan();
      logic [3:0] tdi_seq;
      logic [3:0] tdo_exp;
      tdi_seq = 4'b1101;
      tdo_exp = 4'b1010;
      chk("bypass_en_mode", {bs_enable_o, bs_mode_o}, 2'b00);
      dr_enter();
      chk("bypass_oe", tdo_oe_o, 1'b1);
      for (int k = 0; k < 4; k++) begin
         chk("bypass_tdo", tdo_o, tdo_exp[k]);
         clk(k == 3, tdi_seq[k]);
      end
      chk("bypass_exit_oe", tdo_oe_o, 1'b0);
      clk(1'b1, 1'b0);
      clk(1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] idv;
      logic [7:0]  pat;
      idv = IDV;
      pat = 8'b1011_0010;

      // Reset state
      repeat (2) @(negedge clk_i);
      #1;
      chk("reset_ir", ir_o, RESET_IR);
      chk_all_zero("reset");
      rst_ni = 1'b1;
      clk(1'b0, 1'b0);
      chk("rti_strobes", {bs_capture_dr_o, bs_shift_dr_o, bs_update_dr_o}, 3'b000);
      tdi_i = 1'b1;
      #1;
      chk("scan_in_1", bs_scan_in_o, 1'b1);
      tdi_i = 1'b0;
      #1;
      chk("scan_in_0", bs_scan_in_o, 1'b0);

`ifdef BS_TAP_IDCODE_EN
      // IDCODE scan straight after reset
      dr_enter();
      chk("idcode_oe", tdo_oe_o, 1'b1);
      chk("idcode_bit", tdo_o, idv[0]);
      for (int i = 1; i < 32; i++) begin
         clk(1'b0, 1'(i));
         chk("idcode_bit", tdo_o, idv[i]);
      end
      clk(1'b1, 1'b0);
      chk("idcode_exit_oe", tdo_oe_o, 1'b0);
      chk("idcode_exit_tdo", tdo_o, 1'b0);
      clk(1'b1, 1'b0);
      clk(1'b0, 1'b0);
      load_ir(4'b0110);
      bypass_scan();
`else
      load_ir(4'b0010);
      bypass_scan();
`endif
      load_ir(4'b1111);
      bypass_scan();

      // EXTEST chain scan with strobe counting
      load_ir(4'b0000);
      chk("extest_en_mode", {bs_enable_o, bs_mode_o}, 2'b11);
      ncap = 0; nsh = 0; nupd = 0;
      clk(1'b1, 1'b0);
      clk(1'b0, 1'b0);
      chk("extest_capture", bs_capture_dr_o, 1'b1);
      for (int k = 0; k < 8; k++) begin
         bs_scan_out_i = pat[k];
         clk(1'b0, 1'b0);
         chk("extest_tdo", tdo_o, pat[k]);
      end
      bs_scan_out_i = 1'b0;
      clk(1'b1, 1'b0);
      clk(1'b1, 1'b0);
      chk("extest_update", bs_update_dr_o, 1'b1);
      clk(1'b0, 1'b0);
      chk("extest_ncap", ncap, 1);
      chk("extest_nsh", nsh, 8);
      chk("extest_nupd", nupd, 1);

      // SAMPLE_PRELOAD, then five TMS=1 from SHIFT_DR
      load_ir(4'b0001);
      chk("sample_en_mode", {bs_enable_o, bs_mode_o}, 2'b10);
      dr_enter();
      chk("sample_shift", bs_shift_dr_o, 1'b1);
      repeat (5) clk(1'b1, 1'b0);
      chk("tlr_ir", ir_o, RESET_IR);
      chk_all_zero("tlr");
      clk(1'b0, 1'b0);

      // Async reset mid SHIFT_DR under EXTEST
      load_ir(4'b0000);
      dr_enter();
      chk("pre_reset_shift", bs_shift_dr_o, 1'b1);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("async_ir", ir_o, RESET_IR);
      chk_all_zero("async");
      @(negedge clk_i);
      #1;
      rst_ni = 1'b1;
      clk(1'b0, 1'b0);
      chk("post_reset_ir", ir_o, RESET_IR);
      chk("post_reset_en", bs_enable_o, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
